// File: rtl/plot_pkg.sv
// Shared definitions for the VGA plotting blocks: sequencer states,
// default coordinate/colour widths and common colour codes.
package plot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_X_W = 8;
    localparam int unsigned DEF_Y_W = 7;
    localparam int unsigned DEF_C_W = 3;

    localparam logic [DEF_C_W-1:0] COL_BLACK = 3'b000;
    localparam logic [DEF_C_W-1:0] COL_BLUE  = 3'b001;
    localparam logic [DEF_C_W-1:0] COL_GREEN = 3'b010;
    localparam logic [DEF_C_W-1:0] COL_RED   = 3'b100;
    localparam logic [DEF_C_W-1:0] COL_WHITE = 3'b111;

endpackage

// File: rtl/box_coord_table.sv
// Register file of box origins: async-cleared write port, combinational read.
module box_coord_table #(
    parameter int unsigned N_BOXES = 34,
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned AW      = 6
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           i_we,
    input  logic [AW-1:0]  i_waddr,
    input  logic [X_W-1:0] i_wx,
    input  logic [Y_W-1:0] i_wy,
    input  logic [AW-1:0]  i_raddr,
    output logic [X_W-1:0] o_rx,
    output logic [Y_W-1:0] o_ry
);

    logic [X_W-1:0] r_x [N_BOXES];
    logic [Y_W-1:0] r_y [N_BOXES];
    logic           w_waddr_ok;
    logic           w_raddr_ok;

    // Extra bit keeps the range check correct when N_BOXES is a power of two.
    assign w_waddr_ok = {1'b0, i_waddr} < (AW+1)'(N_BOXES);
    assign w_raddr_ok = {1'b0, i_raddr} < (AW+1)'(N_BOXES);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < int'(N_BOXES); k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
            end
        end else if (i_we && w_waddr_ok) begin
            r_x[i_waddr] <= i_wx;
            r_y[i_waddr] <= i_wy;
        end
    end

    assign o_rx = w_raddr_ok ? r_x[i_raddr] : '0;
    assign o_ry = w_raddr_ok ? r_y[i_raddr] : '0;

endmodule

// File: rtl/box_plot_seq.sv
// Walks the origin table and expands each entry into a BOX_W x BOX_H pixel
// block, one registered pixel per clock, in fill or outline mode.
module box_plot_seq
    import plot_pkg::*;
#(
    parameter int unsigned N_BOXES = 34,
    parameter int unsigned BOX_W   = 3,
    parameter int unsigned BOX_H   = 3,
    parameter int unsigned X_W     = DEF_X_W,
    parameter int unsigned Y_W     = DEF_Y_W,
    parameter int unsigned C_W     = DEF_C_W,
    localparam int unsigned AW     = (N_BOXES > 1) ? $clog2(N_BOXES) : 1,
    localparam int unsigned CW     = $clog2(N_BOXES + 1)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           tbl_we,
    input  logic [AW-1:0]  tbl_addr,
    input  logic [X_W-1:0] tbl_x,
    input  logic [Y_W-1:0] tbl_y,
    input  logic           start,
    input  logic [CW-1:0]  count,
    input  logic [C_W-1:0] colour_in,
    input  logic           outline,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [C_W-1:0] colour,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    localparam int unsigned COLW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int unsigned ROWW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [COLW-1:0] COL_LAST = COLW'(BOX_W - 1);
    localparam logic [ROWW-1:0] ROW_LAST = ROWW'(BOX_H - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_i;
    logic [COLW-1:0] r_col;
    logic [ROWW-1:0] r_row;
    logic [X_W-1:0]  r_ox;
    logic [Y_W-1:0]  r_oy;
    logic [C_W-1:0]  r_colour;
    logic            r_outline;

    logic [X_W-1:0]  w_tx;
    logic [Y_W-1:0]  w_ty;
    logic [CW-1:0]   w_i_next;
    logic [CW-1:0]   w_count_clamp;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_interior;

    box_coord_table #(
        .N_BOXES (N_BOXES),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .AW      (AW)
    ) u_table (
        .clk     (clk),
        .resetn  (resetn),
        .i_we    (tbl_we),
        .i_waddr (tbl_addr),
        .i_wx    (tbl_x),
        .i_wy    (tbl_y),
        .i_raddr (AW'(r_i)),
        .o_rx    (w_tx),
        .o_ry    (w_ty)
    );

    assign w_i_next      = r_i + CW'(1);
    assign w_count_clamp = (count > CW'(N_BOXES)) ? CW'(N_BOXES) : count;
    assign w_col_last    = (r_col == COL_LAST);
    assign w_row_last    = (r_row == ROW_LAST);
    assign w_interior    = (r_col != '0) && !w_col_last && (r_row != '0) && !w_row_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_i       <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_ox      <= '0;
            r_oy      <= '0;
            r_colour  <= '0;
            r_outline <= 1'b0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        if (count == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state   <= ST_FETCH;
                            r_cnt     <= w_count_clamp;
                            r_colour  <= colour_in;
                            r_outline <= outline;
                            r_i       <= '0;
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    plot    <= 1'b0;
                    r_ox    <= w_tx;
                    r_oy    <= w_ty;
                    r_col   <= '0;
                    r_row   <= '0;
                    r_state <= ST_DRAW;
                end
                ST_DRAW: begin
                    // Interior pixels still cost a cycle in outline mode so run length is mode-independent.
                    x      <= r_ox + X_W'(r_col);
                    y      <= r_oy + Y_W'(r_row);
                    colour <= r_colour;
                    plot   <= !(r_outline && w_interior);
                    if (!w_col_last) begin
                        r_col <= r_col + COLW'(1);
                    end else begin
                        r_col <= '0;
                        if (!w_row_last) begin
                            r_row <= r_row + ROWW'(1);
                        end else begin
                            r_row   <= '0;
                            r_i     <= w_i_next;
                            r_state <= (w_i_next < r_cnt) ? ST_FETCH : ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    plot    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_box_plot_seq.sv
// Self-checking bench for box_plot_seq: scenario table plus randomized runs
// compared cycle by cycle against a pixel-timeline reference model.
module tb_box_plot_seq;

    localparam int NB = 34;
    localparam int BW = 3;
    localparam int BH = 3;
    localparam int P  = BW * BH;

    logic       clk;
    logic       resetn;
    logic       tbl_we;
    logic [5:0] tbl_addr;
    logic [7:0] tbl_x;
    logic [6:0] tbl_y;
    logic       start;
    logic [5:0] count;
    logic [2:0] colour_in;
    logic       outline;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int checks;
    int errors;
    int mx [NB];
    int my [NB];

    typedef struct {
        int cnt;
        int col;
        int ol;
        int x0, y0, x1, y1;
        int poke_e;
        int wr_e;
        int exp_done;
        int exp_plots;
        int exp_lx, exp_ly;
    } scen_t;

    scen_t sc [7];

    box_plot_seq #(
        .N_BOXES (34),
        .BOX_W   (3),
        .BOX_H   (3),
        .X_W     (8),
        .Y_W     (7),
        .C_W     (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_x     (tbl_x),
        .tbl_y     (tbl_y),
        .start     (start),
        .count     (count),
        .colour_in (colour_in),
        .outline   (outline),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input int a, input int xv, input int yv);
        tbl_we   = 1'b1;
        tbl_addr = 6'(a);
        tbl_x    = 8'(xv);
        tbl_y    = 7'(yv);
        tick;
        tbl_we = 1'b0;
        if (a < NB) begin
            mx[a] = xv % 256;
            my[a] = yv % 128;
        end
    endtask

    // Expected behaviour: edge 1 is a fetch gap, pixel k of box i lands on
    // edge 2+i*(P+1)+k, done pulses on edge n*(P+1)+1.
    task automatic run_box(input int cnt_in, input int col, input int ol,
                           input int poke_e, input int wr_e, input bit b2b,
                           output int done_e, output int nplot,
                           output int lx, output int ly);
        int n, d, last_e, t, bi, k, c, r, ex, ey;
        bit pix, ep;
        n      = (cnt_in > NB) ? NB : cnt_in;
        d      = n * (P + 1) + 1;
        last_e = b2b ? d : d + 1;
        count     = 6'(cnt_in);
        colour_in = 3'(col);
        outline   = ol[0];
        start     = 1'b1;
        tick;
        start     = 1'b0;
        count     = 6'($urandom);
        colour_in = 3'($urandom);
        outline   = 1'($urandom);
        chk("busy@E0", int'(busy), int'(n != 0));
        chk("done@E0", int'(done), 0);
        done_e = -1;
        nplot  = 0;
        lx     = -1;
        ly     = -1;
        for (int e = 1; e <= last_e; e++) begin
            start = (e == poke_e);
            if (e == wr_e) begin
                tbl_we   = 1'b1;
                tbl_addr = 6'd1;
                tbl_x    = 8'd10;
                tbl_y    = 7'd20;
                mx[1]    = 10;
                my[1]    = 20;
            end
            tick;
            tbl_we = 1'b0;
            start  = 1'b0;
            pix = 1'b0;
            ep  = 1'b0;
            ex  = 0;
            ey  = 0;
            if (n > 0 && e >= 2 && e <= n * (P + 1)) begin
                t  = e - 2;
                bi = t / (P + 1);
                k  = t % (P + 1);
                if (k < P) begin
                    c   = k % BW;
                    r   = k / BW;
                    pix = 1'b1;
                    ex  = (mx[bi] + c) % 256;
                    ey  = (my[bi] + r) % 128;
                    ep  = !(ol != 0 && c > 0 && c < BW - 1 && r > 0 && r < BH - 1);
                end
            end
            chk($sformatf("plot@E%0d", e), int'(plot), int'(ep));
            chk($sformatf("busy@E%0d", e), int'(busy), int'(n > 0 && e < d));
            chk($sformatf("done@E%0d", e), int'(done), int'(e == d));
            if (pix) begin
                chk($sformatf("x@E%0d", e), int'(x), ex);
                chk($sformatf("y@E%0d", e), int'(y), ey);
            end
            if (ep) chk($sformatf("colour@E%0d", e), int'(colour), col);
            if (done === 1'b1 && done_e < 0) done_e = e;
            if (plot === 1'b1) begin
                nplot++;
                lx = int'(x);
                ly = int'(y);
            end
        end
    endtask

    initial begin
        int de, np, lx, ly, n1, n2;
        checks    = 0;
        errors    = 0;
        resetn    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_x     = '0;
        tbl_y     = '0;
        start     = 1'b0;
        count     = '0;
        colour_in = '0;
        outline   = 1'b0;
        for (int k = 0; k < NB; k++) begin
            mx[k] = 0;
            my[k] = 0;
        end

        sc[0] = '{2, 1, 0, 118, 4, 123, 7, 0, 0, 21, 18, 125, 9};
        sc[1] = '{2, 1, 1, 118, 4, 123, 7, 0, 0, 21, 16, 125, 9};
        sc[2] = '{1, 4, 0, 254, 126, 0, 0, 0, 0, 11, 9, 0, 0};
        sc[3] = '{1, 2, 1, 254, 126, 0, 0, 0, 0, 11, 8, 0, 0};
        sc[4] = '{0, 7, 0, 5, 5, 6, 6, 0, 0, 1, 0, 0, 0};
        sc[5] = '{2, 3, 0, 118, 4, 123, 7, 5, 0, 21, 18, 125, 9};
        sc[6] = '{2, 5, 0, 118, 4, 123, 7, 0, 5, 21, 18, 12, 22};

        tick;
        tick;
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        #2 resetn = 1'b1;
        tick;

        for (int s = 0; s < 7; s++) begin
            load(0, sc[s].x0, sc[s].y0);
            load(1, sc[s].x1, sc[s].y1);
            run_box(sc[s].cnt, sc[s].col, sc[s].ol, sc[s].poke_e, sc[s].wr_e, 1'b0,
                    de, np, lx, ly);
            chk($sformatf("sc%0d_done_edge", s), de, sc[s].exp_done);
            chk($sformatf("sc%0d_plots", s), np, sc[s].exp_plots);
            if (sc[s].exp_plots > 0) begin
                chk($sformatf("sc%0d_last_x", s), lx, sc[s].exp_lx);
                chk($sformatf("sc%0d_last_y", s), ly, sc[s].exp_ly);
            end
        end

        // Count above table depth clamps to N_BOXES.
        for (int k = 0; k < NB; k++) load(k, int'($urandom_range(255)), int'($urandom_range(127)));
        run_box(40, 6, 0, 0, 0, 1'b0, de, np, lx, ly);
        chk("clamp_done_edge", de, NB * (P + 1) + 1);
        chk("clamp_plots", np, NB * P);

        // Randomized back-to-back pairs.
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < 6; k++) load(k, int'($urandom_range(255)), int'($urandom_range(127)));
            n1 = int'($urandom_range(5));
            n2 = int'($urandom_range(6));
            run_box(n1, int'($urandom_range(7)), int'($urandom_range(1)), 0, 0, 1'b1, de, np, lx, ly);
            chk($sformatf("rnd%0d_a_done", it), de, n1 * (P + 1) + 1);
            run_box(n2, int'($urandom_range(7)), int'($urandom_range(1)), 0, 0, 1'b0, de, np, lx, ly);
            chk($sformatf("rnd%0d_b_done", it), de, n2 * (P + 1) + 1);
        end

        // Reset dropped mid-DRAW of box 1.
        load(0, 118, 4);
        load(1, 123, 7);
        count     = 6'd2;
        colour_in = 3'd1;
        outline   = 1'b0;
        start     = 1'b1;
        tick;
        start = 1'b0;
        repeat (13) tick;
        chk("pre_rst_plot", int'(plot), 1);
        chk("pre_rst_x", int'(x), 124);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_x", int'(x), 0);
        chk("midrst_y", int'(y), 0);
        chk("midrst_colour", int'(colour), 0);
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        #2 resetn = 1'b1;
        for (int k = 0; k < NB; k++) begin
            mx[k] = 0;
            my[k] = 0;
        end
        for (int e = 0; e < 25; e++) begin
            tick;
            chk($sformatf("post_rst_quiet@%0d", e), int'(plot | busy | done), 0);
        end
        run_box(1, 2, 0, 0, 0, 1'b0, de, np, lx, ly);
        chk("post_rst_table_clear_lx", lx, 2);
        chk("post_rst_table_clear_ly", ly, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/box_plot_seq.md
# box_plot_seq

Parametrised box plotter for the VGA front end. It walks a loadable table of box origins and expands each origin into a BOX_W×BOX_H pixel block. It emits one pixel per clock as x/y/colour/plot to the VGA adapter write port. It replaces single-pixel hard-coded coordinate sequencers: one instance serves any player lane or reset-box set, with fill or outline mode, a programmable box count, and a start/busy/done handshake.

## Interface
- N_BOXES, 34: table depth (max boxes per run).
- BOX_W, 3: box width in pixels (≥1).
- BOX_H, 3: box height in pixels (≥1).
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- C_W, 3: colour width.

- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  clog2(N_BOXES)  table write index; out-of-range writes are ignored.
- tbl_x  in  X_W  box origin x (left).
- tbl_y  in  Y_W  box origin y (top).
- start  in  1  run request, sampled only in IDLE.
- count  in  clog2(N_BOXES+1)  boxes to draw (entries 0..count-1); values above N_BOXES are clamped to N_BOXES.
- colour_in  in  C_W  run colour.
- outline  in  1  1 = plot border pixels only; 0 = fill.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- colour  out  C_W  pixel colour.
- plot  out  1  pixel write enable.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.

## Operation
- Table: N_BOXES entries of {x,y}, cleared to 0 by resetn. Writes are legal at any time. An entry is read only in FETCH, so a write to a not-yet-fetched entry during a run takes effect in that run.
- FSM states: IDLE, FETCH, DRAW, DONE.
  - IDLE → FETCH when start=1 and count≠0. On that transition, latch count, colour_in and outline; set busy=1; set box index i=0.
  - IDLE → DONE when start=1 and count=0.
  - FETCH: register the origin of entry i, clear col and row, go to DRAW. plot=0 in this cycle.
  - DRAW: one pixel per cycle in raster order. col advances 0..BOX_W-1, then row increments. After col=BOX_W-1 and row=BOX_H-1: increment i, then go to FETCH if i<count, else DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Pixel coordinates: x=(ox+col) mod 2^X_W, y=(oy+row) mod 2^Y_W. Results are truncated; there is no saturation.
- Outline mode: interior pixels (0<col<BOX_W-1 and 0<row<BOX_H-1) still take one cycle but drive plot=0. Run length therefore does not depend on mode.
- start while busy is ignored. Inputs other than the table have no effect mid-run.
- resetn low at any time (including mid-DRAW): immediate return to IDLE with all outputs at reset values. No pixels resume after release.

## Timing
- Reset values: x=0, y=0, colour=0, plot=0, busy=0, done=0, state=IDLE.
- All outputs are registered.
- Notation: start is accepted at edge E0; P=BOX_W·BOX_H.
- busy goes high after E0.
- Pixel k of box i is presented after edge E(2+i·(P+1)+k).
- The last pixel of a run is presented after E(n·(P+1)), where n is the latched count.
- done=1, busy=0, plot=0 after E(n·(P+1)+1); done returns low one edge later.
- A start of count=0 gives done after E1 with no plot. busy never rises for that run.
- plot=0 in IDLE, FETCH and DONE. x/y hold their last values there.
- The earliest back-to-back start is accepted on the edge after done (in IDLE).

## Structure
- Shared package plot_pkg holds:
  - the state enum (IDLE/FETCH/DRAW/DONE);
  - default X_W/Y_W/C_W;
  - common colour constants (e.g. COL_BLUE=3'b001, COL_BLACK=3'b000).
- Sub-module box_coord_table holds the N_BOXES×(X_W+Y_W) register file. It has an async-clear write port and a combinational read port indexed by i.
- The top level holds the FSM, the col/row/i counters and the output registers.

## Test plan
- Fill run (defaults): table[0]=(118,4), table[1]=(123,7); start, count=2, colour_in=001, outline=0 → 9 plots at x 118..120, y 4..6 in raster order, first after E2. Then a plot=0 gap at E11, 9 plots at x 123..125, y 7..9 from E12 to E20, and a done pulse after E21.
- Outline mode, same stimulus → pixel (119,5) presented after E6 with plot=0, and (124,8) after E16 with plot=0. All other pixels plot=1. done timing is identical.
- Wrap: table[0]=(254,126), count=1 → x sequence 254,255,0; y rows 126,127,0; no stall.
- count=0 → done after E1, plot never asserted, busy stays 0. count=40 → clamped to 34 boxes, done after E(34·10+1).
- Robustness: start pulsed during DRAW → ignored, the original run completes unchanged. resetn dropped mid-DRAW of box 1 → outputs zero immediately, state IDLE, no further plots.
- Live table update: during box 0 of a count=2 run, write table[1]=(10,20) → box 1 is drawn at x 10..12, y 20..22.
